cache_fill_arbiter: RTL

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter_if.sv | 43 ++++
 rtl/cache_fill_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter_if.sv
// Signal bundle between the fill arbiter, the I/D caches and main memory.
// The arbiter takes the slave view; the surrounding caches/memory take the master view.
interface cache_fill_arbiter_if;
    logic        icache_miss;
    logic [15:0] icache_addr;
    logic        dcache_miss;
    logic [15:0] dcache_addr;
    logic        dcache_wr;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic        dcache_wr_ack;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        busy;

    modport slave (
        input  icache_miss, icache_addr, dcache_miss, dcache_addr,
               dcache_wr, dcache_wr_addr, dcache_wr_data,
               mem_data_valid, mem_data_out,
        output dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
               fill_data, fill_word, fill_we_i, fill_we_d,
               fill_done_i, fill_done_d, busy
    );

    modport master (
        output icache_miss, icache_addr, dcache_miss, dcache_addr,
               dcache_wr, dcache_wr_addr, dcache_wr_data,
               mem_data_valid, mem_data_out,
        input  dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
               fill_data, fill_word, fill_we_i, fill_we_d,
               fill_done_i, fill_done_d, busy
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto one
// main-memory port, streaming block fills back to the owning cache.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS  = 8,
    parameter int MAX_D_STREAK = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_fill_arbiter_if.slave bus
);
    localparam int CW = $clog2(BLOCK_WORDS + 1);
    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] FINAL_IDX  = CW'(BLOCK_WORDS - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [15:0]   base_q, base_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] rcv_q, rcv_d;
    logic [SW-1:0] streak_q, streak_d;

    logic        iForced, grantI, grantDFill, grantWr;
    logic        issuing, rcvOk, lastWord;
    logic [15:0] missAddr;
    logic [3:0]  issueOff;

    // Once D has won MAX_D_STREAK times against a waiting I-miss, I takes the next slot.
    always_comb begin
        iForced    = bus.icache_miss && (streak_q == STREAK_MAX);
        grantI     = (state_q == IDLE) && bus.icache_miss &&
                     (iForced || (!bus.dcache_miss && !bus.dcache_wr));
        grantDFill = (state_q == IDLE) && bus.dcache_miss && !iForced;
        grantWr    = (state_q == IDLE) && bus.dcache_wr && !bus.dcache_miss && !iForced;
        missAddr   = grantDFill ? bus.dcache_addr : bus.icache_addr;
        issuing    = (state_q == FILL) && (issue_q < LAST_CNT);
        issueOff   = 4'({issue_q, 1'b0});
        rcvOk      = (state_q == FILL) && bus.mem_data_valid && (rcv_q < LAST_CNT);
        lastWord   = rcvOk && (rcv_q == FINAL_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            base_q   <= '0;
            issue_q  <= '0;
            rcv_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            base_q   <= base_d;
            issue_q  <= issue_d;
            rcv_q    <= rcv_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        base_d   = base_q;
        issue_d  = issue_q;
        rcv_d    = rcv_q;
        streak_d = streak_q;

        case (state_q)
            IDLE: begin
                if (grantI || grantDFill) begin
                    state_d = FILL;
                    owner_d = grantDFill;
                    base_d  = {missAddr[15:4], 4'h0};
                    issue_d = '0;
                    rcv_d   = '0;
                end
            end
            FILL: begin
                if (issuing) begin
                    issue_d = issue_q + 1'b1;
                end
                if (rcvOk) begin
                    rcv_d = rcv_q + 1'b1;
                end
                if (lastWord) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!bus.icache_miss || grantI) begin
            streak_d = '0;
        end else if ((grantDFill || grantWr) && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Outputs are gated by rst_n so they drop the instant reset asserts, even mid-cycle.
    always_comb begin
        bus.dcache_wr_ack = 1'b0;
        bus.mem_en        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.fill_data     = '0;
        bus.fill_word     = '0;
        bus.fill_we_i     = 1'b0;
        bus.fill_we_d     = 1'b0;
        bus.fill_done_i   = 1'b0;
        bus.fill_done_d   = 1'b0;
        bus.busy          = 1'b0;

        if (rst_n) begin
            bus.busy = (state_q != IDLE);
            if (grantWr) begin
                bus.mem_en        = 1'b1;
                bus.mem_wr        = 1'b1;
                bus.mem_addr      = bus.dcache_wr_addr;
                bus.mem_wdata     = bus.dcache_wr_data;
                bus.dcache_wr_ack = 1'b1;
            end
            if (issuing) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q | {12'h000, issueOff};
            end
            if (rcvOk) begin
                bus.fill_data   = bus.mem_data_out;
                bus.fill_word   = 3'(rcv_q);
                bus.fill_we_i   = !owner_q;
                bus.fill_we_d   = owner_q;
                bus.fill_done_i = lastWord && !owner_q;
                bus.fill_done_d = lastWord && owner_q;
            end
        end
    end
endmodule
